// File: rtl/qpu_exu_measure_collect.sv
// Measurement collector: gathers out-of-order per-qubit readout results for a
// retiring MEASURE and commits them to the regfile as one registered strobe.
//
// Ports:
//   clk, rst_n          core clock, async active-low reset
//   meas_req_valid/ready/list   request handshake (ready only in IDLE)
//   rdo_valid, rdo_data per-qubit readout strobe and result bit
//   timeout_cfg         COLLECT cycle limit, 0 disables the timeout
//   mcu_measure_o_wen/data/list one-cycle commit strobe, results, qubit list
//   meas_busy           high while collecting or committing
//   meas_tmo_err, meas_tmo_clr  sticky timeout flag and its clear
module qpu_exu_measure_collect #(
    parameter int QUBIT_NUM = 12,
    parameter int TMO_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 meas_req_valid,
    output logic                 meas_req_ready,
    input  logic [QUBIT_NUM-1:0] meas_req_list,
    input  logic [QUBIT_NUM-1:0] rdo_valid,
    input  logic [QUBIT_NUM-1:0] rdo_data,
    input  logic [TMO_W-1:0]     timeout_cfg,
    output logic                 mcu_measure_o_wen,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_data,
    output logic [QUBIT_NUM-1:0] mcu_measure_o_list,
    output logic                 meas_busy,
    output logic                 meas_tmo_err,
    input  logic                 meas_tmo_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t               state;
    logic [QUBIT_NUM-1:0] list_r;
    logic [QUBIT_NUM-1:0] pend_r;
    logic [QUBIT_NUM-1:0] data_r;
    logic [TMO_W-1:0]     cnt_r;

    logic [QUBIT_NUM-1:0] hit;
    logic [QUBIT_NUM-1:0] pend_nx;
    logic [QUBIT_NUM-1:0] data_nx;
    logic                 tmo_hit;

    // Only still-pending qubits are captured, so the first arrival wins.
    always_comb begin
        hit     = rdo_valid & pend_r;
        pend_nx = pend_r & ~hit;
        data_nx = (data_r & ~hit) | (rdo_data & hit);
        tmo_hit = (timeout_cfg != '0) &&
                  (cnt_r == timeout_cfg - TMO_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            list_r             <= '0;
            pend_r             <= '0;
            data_r             <= '0;
            cnt_r              <= '0;
            meas_req_ready     <= 1'b1;
            mcu_measure_o_wen  <= 1'b0;
            mcu_measure_o_data <= '0;
            mcu_measure_o_list <= '0;
            meas_busy          <= 1'b0;
            meas_tmo_err       <= 1'b0;
        end else begin
            mcu_measure_o_wen <= 1'b0;
            // A timeout in this cycle overrides the clear below.
            if (meas_tmo_clr)
                meas_tmo_err <= 1'b0;

            unique case (state)
                IDLE: begin
                    // An empty list is consumed without leaving IDLE.
                    if (meas_req_valid && meas_req_ready &&
                        meas_req_list != '0) begin
                        list_r         <= meas_req_list;
                        pend_r         <= meas_req_list;
                        data_r         <= '0;
                        cnt_r          <= '0;
                        state          <= COLLECT;
                        meas_req_ready <= 1'b0;
                        meas_busy      <= 1'b1;
                    end
                end
                COLLECT: begin
                    data_r <= data_nx;
                    pend_r <= pend_nx;
                    if (cnt_r != '1)
                        cnt_r <= cnt_r + TMO_W'(1);
                    // Completion is checked first so it beats the timeout.
                    if (pend_nx == '0) begin
                        state              <= COMMIT;
                        mcu_measure_o_wen  <= 1'b1;
                        mcu_measure_o_data <= data_nx;
                        mcu_measure_o_list <= list_r;
                    end else if (tmo_hit) begin
                        state              <= COMMIT;
                        mcu_measure_o_wen  <= 1'b1;
                        mcu_measure_o_data <= data_nx;
                        mcu_measure_o_list <= list_r;
                        meas_tmo_err       <= 1'b1;
                    end
                end
                COMMIT: begin
                    state          <= IDLE;
                    meas_req_ready <= 1'b1;
                    meas_busy      <= 1'b0;
                end
                default: begin
                    state          <= IDLE;
                    meas_req_ready <= 1'b1;
                    meas_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/qpu_exu_measure_collect.md
Name: qpu_exu_measure_collect

Overview:
- Sits directly upstream of the execution-unit regfile's measurement-result registers.
- Accepts a measurement request (the qubit list of a retiring MEASURE, from the OITF retire path).
- Gathers per-qubit readout results that arrive out of order from the readout electronics.
- When every requested qubit has reported, or on timeout, it drives a one-cycle write strobe with the result vector and measure list. These feed the regfile's mcu_measure_i_wen, mcu_measure_i_data and oitf_ret_i_measurelist inputs.

Parameters:
- QUBIT_NUM, 12, number of physical qubits; width of all qubit vectors.
- TMO_W, 16, width of the timeout counter and of timeout_cfg.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- meas_req_valid  in  1  request valid.
- meas_req_ready  out  1  request ready; high only in IDLE.
- meas_req_list  in  QUBIT_NUM  qubits whose results are awaited.
- rdo_valid  in  QUBIT_NUM  per-qubit result strobe from readout.
- rdo_data  in  QUBIT_NUM  per-qubit result bit, qualified by rdo_valid.
- timeout_cfg  in  TMO_W  COLLECT cycle limit; 0 disables timeout.
- mcu_measure_o_wen  out  1  one-cycle commit strobe.
- mcu_measure_o_data  out  QUBIT_NUM  committed results.
- mcu_measure_o_list  out  QUBIT_NUM  committed qubit list.
- meas_busy  out  1  high in COLLECT or COMMIT.
- meas_tmo_err  out  1  sticky timeout flag.
- meas_tmo_clr  in  1  clears meas_tmo_err.

Behaviour:
- Reset values: all outputs 0 except meas_req_ready=1. State=IDLE. Internal list_r, pend_r, data_r and cnt_r = 0.
- Handshake: a request is accepted when meas_req_valid & meas_req_ready. Inputs are sampled only at acceptance.
- FSM IDLE:
  - On accept with meas_req_list != 0: list_r <= list, pend_r <= list, data_r <= 0, cnt_r <= 0, go to COLLECT.
  - On accept with meas_req_list == 0: consume the request, no commit, stay IDLE.
  - rdo_valid is ignored in IDLE.
- FSM COLLECT (meas_req_ready=0):
  - Each cycle, hit = rdo_valid & pend_r.
  - data_r[k] <= rdo_data[k] for each hit bit; pend_r <= pend_r & ~hit.
  - rdo_valid on non-pending bits (duplicates or unrequested qubits) is ignored; the first arrival wins.
  - cnt_r increments each cycle and saturates at all-ones.
  - If (pend_r & ~hit) == 0, go to COMMIT. Results arriving in the same cycle count.
  - Else if timeout_cfg != 0 and cnt_r == timeout_cfg-1: go to COMMIT. Missing bits stay 0 in data_r; set meas_tmo_err.
  - Completion and timeout in the same cycle: completion wins, no error.
- FSM COMMIT:
  - Registered outputs: mcu_measure_o_wen=1 for exactly one cycle, mcu_measure_o_data=data_r, mcu_measure_o_list=list_r.
  - Next state IDLE.
  - o_data and o_list hold their last committed values until the next commit; the consumer qualifies them with wen.
- Latency:
  - Request accepted at cycle 0; the earliest results are sampled at cycle 1.
  - The last pending result sampled at cycle N gives o_wen high during cycle N+1.
  - A new request can be accepted at cycle N+2 (IDLE).
  - Minimum request-to-request spacing is 3 cycles.
- Timeout: with timeout_cfg=T, a request with no completion commits after T cycles in COLLECT.
- meas_tmo_err is set on timeout and cleared by meas_tmo_clr. Set wins over a simultaneous clear.
- Reset mid-operation: everything returns to reset values; the pending request and partial results are discarded; no wen is issued.
- No combinational path from any input to any output except none: all outputs are registered.

Test Plan:
- Single qubit: req list=0x001 accepted at c0; rdo_valid=0x001, rdo_data=0x001 at c3 -> o_wen=1 at c4, o_data=0x001, o_list=0x001; ready=1 at c5.
- Out-of-order multi-qubit: list=0x0A5; rdo 0x080/d=0x080 at c2, 0x021/d=0x001 at c5, 0x004/d=0 at c7 -> single o_wen at c8 with o_data=0x081, o_list=0x0A5; no wen before c8.
- Duplicate/unrequested: list=0x003; rdo 0x001/d=1 at c2, 0x101/d=0 at c3 (duplicate q0, unrequested q8), 0x002/d=1 at c4 -> o_data=0x003 at c5.
- Timeout: timeout_cfg=4, list=0x00F, only 0x003/d=0x003 at c2 -> o_wen at c5, o_data=0x003, meas_tmo_err=1 from c5 and stays 1; meas_tmo_clr pulse -> 0 the next cycle.
- Boundary: list=0 accepted -> no wen and ready stays 1. Last result arriving on the timeout cycle -> commit without error. meas_req_valid held during COLLECT -> not accepted until IDLE.
- Reset mid-collect: list=0x0FF, assert rst_n=0 at c3 after two results -> outputs 0, ready=1; after release, no o_wen ever emitted for the discarded request.
